// File: rtl/motion_frame_accum.sv
// rtl/motion_frame_accum.sv - per-frame motion statistics from the pixel-difference stream
// Thresholds each difference, accumulates count and bounding box, publishes one record per frame.
module motion_frame_accum #(
  parameter int H_ACTIVE   = 160,
  parameter int V_ACTIVE   = 120,
  parameter int MIN_PIXELS = 16,
  localparam int XW = $clog2(H_ACTIVE),
  localparam int YW = $clog2(V_ACTIVE),
  localparam int CW = $clog2(H_ACTIVE * V_ACTIVE + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_diff_valid,
  input  logic          i_diff_sof,
  input  logic [7:0]    i_diff,
  input  logic [7:0]    i_thresh,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic [CW-1:0] o_res_count,
  output logic [XW-1:0] o_res_xmin,
  output logic [XW-1:0] o_res_xmax,
  output logic [YW-1:0] o_res_ymin,
  output logic [YW-1:0] o_res_ymax,
  output logic          o_res_motion,
  output logic          o_frame_err,
  output logic          o_res_dropped
);

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t        r_state;
  state_t        w_state_n;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [7:0]    r_thr;
  logic [CW-1:0] r_cnt;
  logic [XW-1:0] r_xmin;
  logic [XW-1:0] r_xmax;
  logic [YW-1:0] r_ymin;
  logic [YW-1:0] r_ymax;

  logic          r_res_valid;
  logic [CW-1:0] r_res_count;
  logic [XW-1:0] r_res_xmin;
  logic [XW-1:0] r_res_xmax;
  logic [YW-1:0] r_res_ymin;
  logic [YW-1:0] r_res_ymax;
  logic          r_res_motion;
  logic          r_frame_err;
  logic          r_res_dropped;

  logic          w_start;
  logic          w_take;
  logic          w_early;
  logic          w_motion;
  logic          w_first;
  logic          w_last;
  logic [7:0]    w_thr;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;
  logic [CW-1:0] w_cnt_b;
  logic [XW-1:0] w_xmin_b;
  logic [XW-1:0] w_xmax_b;
  logic [YW-1:0] w_ymin_b;
  logic [YW-1:0] w_ymax_b;
  logic [CW-1:0] w_cnt_n;
  logic [XW-1:0] w_xmin_n;
  logic [XW-1:0] w_xmax_n;
  logic [YW-1:0] w_ymin_n;
  logic [YW-1:0] w_ymax_n;
  logic [XW-1:0] w_x_n;
  logic [YW-1:0] w_y_n;

  // A sof pixel always restarts the frame: the base values seen by this pixel are cleared.
  assign w_start  = i_diff_valid & i_diff_sof;
  assign w_take   = i_diff_valid & (i_diff_sof | (r_state == S_ACCUM));
  assign w_early  = w_start & (r_state == S_ACCUM) & ((r_x != '0) | (r_y != '0));
  assign w_thr    = w_start ? i_thresh : r_thr;
  assign w_px     = w_start ? '0 : r_x;
  assign w_py     = w_start ? '0 : r_y;
  assign w_cnt_b  = w_start ? '0 : r_cnt;
  assign w_xmin_b = w_start ? '0 : r_xmin;
  assign w_xmax_b = w_start ? '0 : r_xmax;
  assign w_ymin_b = w_start ? '0 : r_ymin;
  assign w_ymax_b = w_start ? '0 : r_ymax;
  assign w_motion = w_take & (i_diff > w_thr);
  assign w_first  = (w_cnt_b == '0);
  assign w_last   = w_take & (w_px == X_LAST) & (w_py == Y_LAST);

  always_comb begin
    w_cnt_n  = w_cnt_b;
    w_xmin_n = w_xmin_b;
    w_xmax_n = w_xmax_b;
    w_ymin_n = w_ymin_b;
    w_ymax_n = w_ymax_b;
    if (w_motion) begin
      w_cnt_n = w_cnt_b + CW'(1);
      if (w_first) begin
        w_xmin_n = w_px;
        w_xmax_n = w_px;
        w_ymin_n = w_py;
        w_ymax_n = w_py;
      end else begin
        w_xmin_n = (w_px < w_xmin_b) ? w_px : w_xmin_b;
        w_xmax_n = (w_px > w_xmax_b) ? w_px : w_xmax_b;
        w_ymin_n = (w_py < w_ymin_b) ? w_py : w_ymin_b;
        w_ymax_n = (w_py > w_ymax_b) ? w_py : w_ymax_b;
      end
    end
  end

  always_comb begin
    w_x_n = w_px + XW'(1);
    w_y_n = w_py;
    if (w_last) begin
      w_x_n = '0;
      w_y_n = '0;
    end else if (w_px == X_LAST) begin
      w_x_n = '0;
      w_y_n = w_py + YW'(1);
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (w_take) begin
      w_state_n = w_last ? S_IDLE : S_ACCUM;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_thr  <= '0;
      r_cnt  <= '0;
      r_xmin <= '0;
      r_xmax <= '0;
      r_ymin <= '0;
      r_ymax <= '0;
    end else if (w_take) begin
      r_x    <= w_x_n;
      r_y    <= w_y_n;
      r_thr  <= w_thr;
      r_cnt  <= w_cnt_n;
      r_xmin <= w_xmin_n;
      r_xmax <= w_xmax_n;
      r_ymin <= w_ymin_n;
      r_ymax <= w_ymax_n;
    end
  end

  // An overwrite only counts as a drop when the pending record is not taken in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_res_valid   <= 1'b0;
      r_res_count   <= '0;
      r_res_xmin    <= '0;
      r_res_xmax    <= '0;
      r_res_ymin    <= '0;
      r_res_ymax    <= '0;
      r_res_motion  <= 1'b0;
      r_res_dropped <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_err <= w_early;
      if (w_last) begin
        r_res_valid  <= 1'b1;
        r_res_count  <= w_cnt_n;
        r_res_xmin   <= w_xmin_n;
        r_res_xmax   <= w_xmax_n;
        r_res_ymin   <= w_ymin_n;
        r_res_ymax   <= w_ymax_n;
        r_res_motion <= (int'(w_cnt_n) >= MIN_PIXELS);
        if (r_res_valid && !i_res_ready) begin
          r_res_dropped <= 1'b1;
        end
      end else if (r_res_valid && i_res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_res_valid   = r_res_valid;
  assign o_res_count   = r_res_count;
  assign o_res_xmin    = r_res_xmin;
  assign o_res_xmax    = r_res_xmax;
  assign o_res_ymin    = r_res_ymin;
  assign o_res_ymax    = r_res_ymax;
  assign o_res_motion  = r_res_motion;
  assign o_frame_err   = r_frame_err;
  assign o_res_dropped = r_res_dropped;

endmodule

// File: tb/tb_motion_frame_accum.sv
// tb/tb_motion_frame_accum.sv - randomized self-checking bench for motion_frame_accum
module tb_motion_frame_accum;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int MIN = 2;
  localparam int N   = H * V;
  localparam int XW  = $clog2(H);
  localparam int YW  = $clog2(V);
  localparam int CW  = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_diff_valid;
  logic          i_diff_sof;
  logic [7:0]    i_diff;
  logic [7:0]    i_thresh;
  logic          o_res_valid;
  logic          i_res_ready;
  logic [CW-1:0] o_res_count;
  logic [XW-1:0] o_res_xmin;
  logic [XW-1:0] o_res_xmax;
  logic [YW-1:0] o_res_ymin;
  logic [YW-1:0] o_res_ymax;
  logic          o_res_motion;
  logic          o_frame_err;
  logic          o_res_dropped;

  motion_frame_accum #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MIN)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_diff_valid (i_diff_valid),
    .i_diff_sof   (i_diff_sof),
    .i_diff       (i_diff),
    .i_thresh     (i_thresh),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res_count  (o_res_count),
    .o_res_xmin   (o_res_xmin),
    .o_res_xmax   (o_res_xmax),
    .o_res_ymin   (o_res_ymin),
    .o_res_ymax   (o_res_ymax),
    .o_res_motion (o_res_motion),
    .o_frame_err  (o_frame_err),
    .o_res_dropped(o_res_dropped)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fd [N];
  logic [7:0] fthr;
  int m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
  int h_cnt, h_xmin, h_xmax, h_ymin, h_ymax;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: scan the frame in raster order and keep a plain min/max box of motion pixels.
  task automatic model();
    m_cnt = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (fd[y*H + x] > fthr) begin
          if (m_cnt == 0) begin
            m_xmin = x; m_xmax = x; m_ymin = y; m_ymax = y;
          end else begin
            if (x < m_xmin) m_xmin = x;
            if (x > m_xmax) m_xmax = x;
            if (y < m_ymin) m_ymin = y;
            if (y > m_ymax) m_ymax = y;
          end
          m_cnt++;
        end
      end
    end
  endtask

  task automatic save_hold();
    h_cnt = m_cnt; h_xmin = m_xmin; h_xmax = m_xmax; h_ymin = m_ymin; h_ymax = m_ymax;
  endtask

  task automatic rand_frame();
    fthr = 8'($urandom_range(17, 0));
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(3, 0))
        0:       fd[i] = 8'($urandom_range(255, 0));
        1:       fd[i] = fthr;
        default: fd[i] = 8'($urandom_range(17, 0));
      endcase
    end
  endtask

  task automatic drive_px(input logic sof, input logic [7:0] d);
    i_diff_valid = 1'b1;
    i_diff_sof   = sof;
    i_diff       = d;
    i_thresh     = sof ? fthr : 8'($urandom);
    @(negedge clk);
    i_diff_valid = 1'b0;
    i_diff_sof   = 1'($urandom);
    i_diff       = 8'($urandom);
    i_thresh     = 8'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_diff_valid = 1'b0;
      i_diff_sof   = 1'($urandom);
      i_diff       = 8'($urandom);
      i_thresh     = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input int gap_lo, input int gap_hi, input logic exp_err,
                            input int npix, input logic hold_chk);
    for (int i = 0; i < npix; i++) begin
      if (i > 0) idle($urandom_range(gap_hi, gap_lo));
      drive_px(i == 0, fd[i]);
      if (i == 0) check("frame_err", 32'(o_frame_err), 32'(exp_err));
      if (i == 1) check("frame_err_off", 32'(o_frame_err), 0);
      if (hold_chk && i < N - 1) begin
        check("hold_valid", 32'(o_res_valid), 1);
        check("hold_count", 32'(o_res_count), h_cnt);
        check("hold_box", {o_res_xmin, o_res_xmax, o_res_ymin, o_res_ymax},
              32'({XW'(h_xmin), XW'(h_xmax), YW'(h_ymin), YW'(h_ymax)}));
      end
    end
  endtask

  task automatic check_rec(input string t);
    check({t, "_valid"}, 32'(o_res_valid), 1);
    check({t, "_count"}, 32'(o_res_count), m_cnt);
    check({t, "_xmin"}, 32'(o_res_xmin), m_xmin);
    check({t, "_xmax"}, 32'(o_res_xmax), m_xmax);
    check({t, "_ymin"}, 32'(o_res_ymin), m_ymin);
    check({t, "_ymax"}, 32'(o_res_ymax), m_ymax);
    check({t, "_motion"}, 32'(o_res_motion), (m_cnt >= MIN) ? 1 : 0);
  endtask

  task automatic take_and_check(input string t);
    i_res_ready = 1'b1;
    idle(1);
    check({t, "_cleared"}, 32'(o_res_valid), 0);
  endtask

  task automatic check_all_zero(input string t);
    check({t, "_valid"}, 32'(o_res_valid), 0);
    check({t, "_fields"}, {o_res_count, o_res_xmin, o_res_xmax, o_res_ymin, o_res_ymax}, 0);
    check({t, "_flags"}, {o_res_motion, o_frame_err, o_res_dropped}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_res_ready = 1'b0; fthr = 8'd0;
    i_diff_valid = 1'b0; i_diff_sof = 1'b0; i_diff = 8'd0; i_thresh = 8'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    i_reset = 1'b0;
    idle(2);

    // directed motion frame
    fthr = 8'd5;
    for (int i = 0; i < N; i++) fd[i] = 8'd0;
    fd[1] = 8'd6; fd[2*H + 3] = 8'd17;
    model();
    send_frame(0, 0, 1'b0, N, 1'b0);
    check_rec("dir1");
    check("dir1_cnt_const", 32'(o_res_count), 2);
    take_and_check("dir1");

    // differences equal to threshold are not motion
    for (int i = 0; i < N; i++) fd[i] = 8'd5;
    model();
    send_frame(0, 0, 1'b0, N, 1'b0);
    check_rec("eq");
    check("eq_cnt_const", 32'(o_res_count), 0);
    take_and_check("eq");

    // early sof at (2,1)
    rand_frame();
    send_frame(0, 0, 1'b0, H + 2, 1'b0);
    check("early_norec", 32'(o_res_valid), 0);
    rand_frame();
    model();
    send_frame(0, 0, 1'b1, N, 1'b0);
    check_rec("early");
    take_and_check("early");

    // overwrite with the old record taken in the same cycle
    i_res_ready = 1'b0;
    rand_frame(); model();
    send_frame(0, 0, 1'b0, N, 1'b0);
    check_rec("ovr_a");
    save_hold();
    rand_frame(); model();
    send_frame(0, 0, 1'b0, N - 1, 1'b1);
    i_res_ready = 1'b1;
    drive_px(1'b0, fd[N-1]);
    i_res_ready = 1'b0;
    check_rec("ovr_b");
    check("ovr_nodrop", 32'(o_res_dropped), 0);
    take_and_check("ovr");

    // back-to-back frames with ready low: second record overwrites, drop is sticky
    i_res_ready = 1'b0;
    rand_frame(); model();
    send_frame(0, 0, 1'b0, N, 1'b0);
    check_rec("drop_a");
    save_hold();
    rand_frame(); model();
    send_frame(0, 0, 1'b0, N, 1'b1);
    check_rec("drop_b");
    check("drop_set", 32'(o_res_dropped), 1);
    take_and_check("drop");
    check("drop_sticky", 32'(o_res_dropped), 1);

    // reset mid-frame with a record pending
    i_res_ready = 1'b0;
    rand_frame(); model();
    send_frame(0, 0, 1'b0, N, 1'b0);
    rand_frame();
    send_frame(0, 0, 1'b0, H + 1, 1'b0);
    i_reset = 1'b1;
    idle(1);
    check_all_zero("midreset");
    i_reset = 1'b0;
    rand_frame(); model();
    send_frame(0, 0, 1'b0, N, 1'b0);
    check_rec("postreset");
    take_and_check("postreset");

    // randomized frames: alternating-valid and random gaps, junk pixels before sof
    for (int k = 0; k < 16; k++) begin
      i_res_ready = 1'b1;
      for (int j = 0; j < $urandom_range(3, 1); j++) drive_px(1'b0, 8'($urandom_range(255, 100)));
      rand_frame(); model();
      if (k % 2 == 0) send_frame(1, 1, 1'b0, N, 1'b0);
      else            send_frame(0, 3, 1'b0, N, 1'b0);
      check_rec("rnd");
      idle(1);
      check("rnd_cleared", 32'(o_res_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
